// File: rtl/width_8to16_arb.sv
// Round-robin arbiter that shares one 8-to-16 packing datapath between NUM_REQ
// byte-stream requesters; a grant is held until its word is complete or times out.
module width_8to16_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 valid_out,
  output logic [15:0]          data_out,
  output logic [ID_W-1:0]      id_out,
  input  logic                 out_ready,
  output logic                 timeout_err,
  output logic [ID_W-1:0]      err_id
);

  if ((2 ** ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("width_8to16_arb: ID_W too narrow to encode NUM_REQ sources");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [7:0]      TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST_REQ   = ID_W'(NUM_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W-1:0] gnt, gnt_nxt;
  logic [7:0]      timer, timer_nxt;
  logic [7:0]      hi, hi_nxt;
  logic            valid_nxt;
  logic [15:0]     data_nxt;
  logic [ID_W-1:0] id_nxt;
  logic            err_nxt;
  logic [ID_W-1:0] err_id_nxt;

  logic [7:0] req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // Round-robin search: first valid requester at or after ptr, wrapping.
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  logic first_take;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gnt_nxt    = gnt;
    timer_nxt  = timer;
    hi_nxt     = hi;
    valid_nxt  = valid_out;
    data_nxt   = data_out;
    id_nxt     = id_out;
    err_nxt    = 1'b0;
    err_id_nxt = err_id;
    req_ready  = '0;
    first_take = 1'b0;

    case (state)
      S_IDLE: begin
        first_take = win_found;
      end
      S_LOCK: begin
        req_ready = NUM_REQ'(1) << gnt;
        if (req_valid[gnt]) begin
          data_nxt  = {hi, req_byte[gnt]};
          id_nxt    = gnt;
          valid_nxt = 1'b1;
          state_nxt = S_OUT;
        end else if (TIMEOUT != 0 && timer == TIMER_LAST) begin
          err_nxt    = 1'b1;
          err_id_nxt = gnt;
          hi_nxt     = '0;
          state_nxt  = S_IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          valid_nxt  = 1'b0;
          state_nxt  = S_IDLE;
          first_take = win_found;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A first byte may be taken from IDLE or while the output word drains.
    if (first_take) begin
      req_ready = NUM_REQ'(1) << win_idx;
      hi_nxt    = req_byte[win_idx];
      gnt_nxt   = win_idx;
      ptr_nxt   = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
      timer_nxt = '0;
      state_nxt = S_LOCK;
    end

    if (rst) req_ready = '0;
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gnt         <= '0;
      timer       <= '0;
      hi          <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      id_out      <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      gnt         <= gnt_nxt;
      timer       <= timer_nxt;
      hi          <= hi_nxt;
      valid_out   <= valid_nxt;
      data_out    <= data_nxt;
      id_out      <= id_nxt;
      timeout_err <= err_nxt;
      err_id      <= err_id_nxt;
    end
  end

endmodule
